// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if
//   Processor data-port bus between a load/store master and the
//   data_mem_responder memory target.
//
//   Handshake: the master raises Req together with MemWrite, DataAdr and
//   WriteData. The target samples them only while it is idle. Busy marks an
//   accepted transaction in flight. Ack is a one-cycle completion pulse, and
//   Err/ReadData belong to that response. The master holds Req until it sees
//   Ack, or drops it after the acceptance edge. Both forms are legal.
//
//   Signals:
//     Req        master -> target  access request
//     MemWrite   master -> target  1 = store, 0 = load
//     DataAdr    master -> target  byte address
//     WriteData  master -> target  store data
//     ReadData   target -> master  load data, held between loads
//     Ack        target -> master  one-cycle completion pulse
//     Err        target -> master  error status, meaningful while Ack=1
//     Busy       target -> master  transaction in progress (WAIT/ACK)
interface data_mem_responder_if;
   logic        Req;
   logic        MemWrite;
   logic [31:0] DataAdr;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        Ack;
   logic        Err;
   logic        Busy;

   modport master (
      output Req, MemWrite, DataAdr, WriteData,
      input  ReadData, Ack, Err, Busy
   );

   modport slave (
      input  Req, MemWrite, DataAdr, WriteData,
      output ReadData, Ack, Err, Busy
   );
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Multi-cycle data-memory target with a word-addressed internal RAM. An
//   accepted request waits WAIT_CYCLES cycles and then gets a one-cycle Ack.
//   An access outside the RAM receives Err=1 and does not touch storage.
//
//   Parameters:
//     DEPTH        number of 32-bit words (power of two, >= 2)
//     WAIT_CYCLES  wait states between acceptance and Ack (0..15)
//
//   Ports:
//     clk        rising-edge clock
//     Reset      synchronous active-high reset
//     bus        data_mem_responder_if.slave (Req/MemWrite/DataAdr/WriteData
//                in; ReadData/Ack/Err/Busy out)
//     dbg_state  current FSM state (0 idle, 1 wait, 2 ack)
//
//   Optional feature macro: DMEM_ALIGN_CHECK_EN. When it is defined, an access
//   with DataAdr[1:0] != 0 also responds with Err=1.
module data_mem_responder #(
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  Reset,
   data_mem_responder_if.slave   bus,
   output logic [1:0]            dbg_state
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   logic [1:0]    state;
   logic [3:0]    count;

   logic          req_write;
   logic [31:0]   req_adr;
   logic [31:0]   req_wdata;

   logic [31:0]   mem [DEPTH];

   logic [31:0]   rdata_q;
   logic          err_q;

   // Request fields used at the response edge. With WAIT_CYCLES=0, the
   // response edge is the acceptance edge itself, so the request registers
   // do not hold the request yet. In that case the inputs are used directly.
   logic          acc_write;
   logic [31:0]   acc_adr;
   logic [31:0]   acc_wdata;
   logic [AW-1:0] acc_idx;
   logic          acc_bad;
   logic          respond;

   always_comb begin
      acc_write = req_write;
      acc_adr   = req_adr;
      acc_wdata = req_wdata;
      if (state == S_IDLE) begin
         acc_write = bus.MemWrite;
         acc_adr   = bus.DataAdr;
         acc_wdata = bus.WriteData;
      end
   end

   assign acc_idx = acc_adr[AW+1:2];

   // If any address bit above the word index is set, the access is beyond the RAM.
   always_comb begin
      acc_bad = ((acc_adr >> (AW + 2)) != 32'd0);
`ifdef DMEM_ALIGN_CHECK_EN
      if (acc_adr[1:0] != 2'b00) begin
         acc_bad = 1'b1;
      end
`endif
   end

   // This is the edge that enters ACK. It comes from a WAIT state with an
   // expired counter, or from IDLE when there are no wait states.
   assign respond = ((state == S_WAIT) && (count == 4'd0)) ||
                    ((state == S_IDLE) && bus.Req && (WAIT_CYCLES == 0));

   always_ff @(posedge clk) begin
      if (Reset) begin
         state   <= S_IDLE;
         count   <= 4'd0;
         err_q   <= 1'b0;
         rdata_q <= 32'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.Req) begin
                  req_write <= bus.MemWrite;
                  req_adr   <= bus.DataAdr;
                  req_wdata <= bus.WriteData;
                  if (WAIT_CYCLES == 0) begin
                     state <= S_ACK;
                  end else begin
                     state <= S_WAIT;
                     count <= CNT_INIT;
                  end
               end
            end
            S_WAIT: begin
               if (count == 4'd0) begin
                  state <= S_ACK;
               end else begin
                  count <= count - 4'd1;
               end
            end
            S_ACK: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase

         if (respond) begin
            err_q <= acc_bad;
            if (!acc_write) begin
               rdata_q <= acc_bad ? 32'd0 : mem[acc_idx];
            end
         end
      end
   end

   // The RAM has no reset. Reset blocks a store that is still pending.
   always_ff @(posedge clk) begin
      if (!Reset && respond && acc_write && !acc_bad) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   assign bus.ReadData = rdata_q;
   assign bus.Err      = err_q;
   assign bus.Ack      = (state == S_ACK);
   assign bus.Busy     = (state != S_IDLE);
   assign dbg_state    = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//   Drives two responders: dut0 with WAIT_CYCLES=2 and dut1 with
//   WAIT_CYCLES=0. A cycle-level model predicts Ack, Busy, Err and ReadData
//   from acceptance times and an array copy of the RAM. A compare process
//   checks every negedge. Directed literal checks anchor the model.
module tb_data_mem_responder;
   localparam int DEPTH = 64;
   localparam int W0    = 2;
   localparam int W1    = 0;

   logic clk = 1'b0;
   logic Reset;
   always #5 clk = ~clk;

   data_mem_responder_if bus0();
   data_mem_responder_if bus1();
   logic [1:0] dbg0, dbg1;

   logic        req [2];
   logic        mw  [2];
   logic [31:0] adr [2];
   logic [31:0] wd  [2];

   assign bus0.Req = req[0];
   assign bus0.MemWrite = mw[0];
   assign bus0.DataAdr = adr[0];
   assign bus0.WriteData = wd[0];
   assign bus1.Req = req[1];
   assign bus1.MemWrite = mw[1];
   assign bus1.DataAdr = adr[1];
   assign bus1.WriteData = wd[1];

   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .Reset(Reset), .bus(bus0), .dbg_state(dbg0)
   );
   data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W1)) dut1 (
      .clk(clk), .Reset(Reset), .bus(bus1), .dbg_state(dbg1)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          wk [2] = '{W0, W1};
   logic [31:0] mmem [2][DEPTH];
   bit          m_active [2] = '{0, 0};
   longint      m_t0 [2]     = '{0, 0};
   logic        m_w [2];
   logic [31:0] m_a [2];
   logic [31:0] m_d [2];
   logic        e_ack [2]  = '{0, 0};
   logic        e_busy [2] = '{0, 0};
   logic        e_err [2]  = '{0, 0};
   logic [31:0] e_rd [2]   = '{32'd0, 32'd0};
   longint      cyc = 0;

   function automatic bit bad_addr(input logic [31:0] a);
      bit b;
      b = (a >= 32'(4 * DEPTH));
`ifdef DMEM_ALIGN_CHECK_EN
      if (a[1:0] != 2'b00) b = 1'b1;
`endif
      return b;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (Reset) begin
            m_active[k] = 0;
            e_err[k] = 1'b0;
            e_rd[k] = 32'd0;
         end else begin
            // The target is idle again W+2 edges after it accepts a request.
            if ((!m_active[k] || cyc >= m_t0[k] + wk[k] + 2) && req[k]) begin
               m_active[k] = 1;
               m_t0[k] = cyc;
               m_w[k] = mw[k];
               m_a[k] = adr[k];
               m_d[k] = wd[k];
            end
            if (m_active[k] && cyc == m_t0[k] + wk[k]) begin
               e_err[k] = bad_addr(m_a[k]);
               if (m_w[k]) begin
                  if (!e_err[k]) mmem[k][m_a[k] / 4] = m_d[k];
               end else begin
                  e_rd[k] = e_err[k] ? 32'd0 : mmem[k][m_a[k] / 4];
               end
            end
         end
         e_ack[k]  = !Reset && m_active[k] && (cyc == m_t0[k] + wk[k]);
         e_busy[k] = !Reset && m_active[k] && (cyc >= m_t0[k]) && (cyc <= m_t0[k] + wk[k]);
      end
      cyc++;
   end

   // ---------------- per-cycle compare ----------------
   int busy_cnt0 = 0;
   always @(negedge clk) begin
      check("ack0", {31'd0, bus0.Ack}, {31'd0, e_ack[0]});
      check("busy0", {31'd0, bus0.Busy}, {31'd0, e_busy[0]});
      check("rdata0", bus0.ReadData, e_rd[0]);
      if (e_ack[0]) check("err0", {31'd0, bus0.Err}, {31'd0, e_err[0]});
      check("ack1", {31'd0, bus1.Ack}, {31'd0, e_ack[1]});
      check("busy1", {31'd0, bus1.Busy}, {31'd0, e_busy[1]});
      check("rdata1", bus1.ReadData, e_rd[1]);
      if (e_ack[1]) check("err1", {31'd0, bus1.Err}, {31'd0, e_err[1]});
      if (bus0.Busy === 1'b1) busy_cnt0++;
   end

   // ---------------- driver ----------------
   // One access on dut0. It returns at the negedge of the Ack cycle, and lat
   // counts the edges from the request cycle to that Ack.
   task automatic access0(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input bit churn, output int lat);
      @(negedge clk);
      req[0] = 1'b1; mw[0] = w; adr[0] = a; wd[0] = d;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         req[0] = 1'b0;
         if (churn) begin
            mw[0]  = ~mw[0];
            adr[0] = adr[0] + 32'h44;
            wd[0]  = ~wd[0];
         end
      end while (bus0.Ack !== 1'b1 && lat < 40);
      if (bus0.Ack !== 1'b1) begin
         n_checks++;
         n_fail++;
         $display("FAIL ack_timeout0: got no Ack, expected Ack within 40 cycles");
      end
   endtask

   initial begin
      int lat;
      int b0;
      int acks;

      Reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; mw[k] = 1'b0; adr[k] = 32'd0; wd[k] = 32'd0;
      end
      for (int i = 0; i < DEPTH; i++) begin
         dut0.mem[i] = 32'h1000_0000 + 32'(i);
         dut1.mem[i] = 32'h1000_0000 + 32'(i);
         mmem[0][i]  = 32'h1000_0000 + 32'(i);
         mmem[1][i]  = 32'h1000_0000 + 32'(i);
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_ack", {31'd0, bus0.Ack}, 32'd0);
      check("reset_rdata", bus0.ReadData, 32'd0);
      Reset = 1'b0;

      // Store and then load at 0x10. Expect latency 3 and three Busy cycles.
      access0(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat);
      check("store_latency", 32'(lat), 32'd3);
      b0 = busy_cnt0;
      access0(1'b0, 32'h10, 32'h0, 1'b0, lat);
      check("load_latency", 32'(lat), 32'd3);
      check("load_rdata", bus0.ReadData, 32'hDEADBEEF);
      check("load_err", {31'd0, bus0.Err}, 32'd0);
      check("busy_cycles", 32'(busy_cnt0 - b0), 32'd3);

      // Out-of-range accesses.
      access0(1'b1, 32'h100, 32'h12345678, 1'b0, lat);
      check("oor_store_err", {31'd0, bus0.Err}, 32'd1);
      access0(1'b0, 32'h0, 32'h0, 1'b0, lat);
      check("mem0_untouched", bus0.ReadData, 32'h1000_0000);
      access0(1'b0, 32'h100, 32'h0, 1'b0, lat);
      check("oor_load_rdata", bus0.ReadData, 32'd0);
      check("oor_load_err", {31'd0, bus0.Err}, 32'd1);

      // Highest in-range word.
      access0(1'b1, 32'hFC, 32'h0BAD_F00D, 1'b0, lat);
      access0(1'b0, 32'hFC, 32'h0, 1'b0, lat);
      check("top_word", bus0.ReadData, 32'h0BAD_F00D);

      // Inputs that churn during WAIT must not affect the captured request.
      access0(1'b1, 32'h20, 32'h55667788, 1'b1, lat);
      access0(1'b0, 32'h20, 32'h0, 1'b1, lat);
      check("churn_rdata", bus0.ReadData, 32'h55667788);

      // Misaligned load.
      access0(1'b0, 32'h13, 32'h0, 1'b0, lat);
`ifdef DMEM_ALIGN_CHECK_EN
      check("align_rdata", bus0.ReadData, 32'd0);
      check("align_err", {31'd0, bus0.Err}, 32'd1);
`else
      check("align_rdata", bus0.ReadData, 32'hDEADBEEF);
      check("align_err", {31'd0, bus0.Err}, 32'd0);
`endif

      // Reset during the last WAIT cycle of a store.
      @(negedge clk);
      req[0] = 1'b1; mw[0] = 1'b1; adr[0] = 32'h8; wd[0] = 32'hAAAA5555;
      @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0;
      @(posedge clk);
      @(negedge clk);
      Reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Reset = 1'b0;
      check("rst_mid_ack", {31'd0, bus0.Ack}, 32'd0);
      check("rst_mid_busy", {31'd0, bus0.Busy}, 32'd0);
      check("rst_mid_err", {31'd0, bus0.Err}, 32'd0);
      check("rst_mid_rdata", bus0.ReadData, 32'd0);
      repeat (3) @(negedge clk);
      access0(1'b0, 32'h8, 32'h0, 1'b0, lat);
      check("rst_store_dropped", bus0.ReadData, 32'h1000_0002);

      // No wait states, with Req held high: a store followed by loads.
      @(negedge clk);
      req[1] = 1'b1; mw[1] = 1'b1; adr[1] = 32'h4; wd[1] = 32'hCAFEF00D;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (bus1.Ack === 1'b1) acks++;
         if (i == 0) begin
            check("w0_store_ack", {31'd0, bus1.Ack}, 32'd1);
            mw[1] = 1'b0;
         end
         if (i == 2) check("w0_first_load", bus1.ReadData, 32'hCAFEF00D);
      end
      req[1] = 1'b0;
      check("w0_ack_count", 32'(acks), 32'd3);

      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got timeout, expected test end");
      $fatal(1, "timeout");
   end
endmodule
